sys_counter_unit: RTL and testbench
===================================

# sys_counter_unit

Execute-stage system unit for the multicore processor: it services the `t_sysop` instructions RDCYCLE, RDTIME and RDINSTRET, plus their H variants, for every hart, and raises traps for SCALL/SBREAK. It generalises the single-hart system op set in three ways: a hart count, a counter width, and a time prescaler. It also provides torn-read-free 64-bit counter reads over the 32-bit datapath by latching the high half when the low half is read. It sits beside the ALU and branch units, selected when `t_exe_unit` is SYSTEM.

## Interface
Parameters:
- `NUM_HARTS`, 4: number of harts sharing the unit; ≥1.
- `DATA_SIZE`, 32: datapath width.
- `CNT_WIDTH`, 64: counter width; must equal 2*DATA_SIZE.
- `TIME_DIV`, 50: clk cycles per time tick; ≥1.
- `HART_BITS`, derived: max(1, $clog2(NUM_HARTS)).

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
  - `clk`, in, 1: clock.
  - `rst_n`, in, 1: reset, synchronous, active-low.
- Request channel:
  - `req_valid`, in, 1: request present.
  - `req_ready`, out, 1: unit can accept a request.
  - `req_hart`, in, HART_BITS: requesting hart.
  - `req_op`, in, 3: a `t_sysop` value.
- Response channel:
  - `resp_valid`, out, 1: one-cycle response pulse.
  - `resp_hart`, out, HART_BITS: hart of the response.
  - `resp_data`, out, DATA_SIZE: counter half.
- Retire and trap:
  - `retire`, in, NUM_HARTS: per-hart instruction-retired pulse.
  - `trap_pending`, out, 1: SCALL/SBREAK trap outstanding.
  - `trap_cause`, out, 1: 0 = SCALL, 1 = SBREAK.
  - `trap_ack`, in, 1: trap consumed by the pipeline.

## Operation
- **cycle** counter: one shared counter, +1 every clk.
- **time** counter: one shared counter. The prescaler counts 0..TIME_DIV-1; time increments in the cycle the prescaler wraps to 0.
- **instret[h]** counter: +1 in each cycle where `retire[h]` = 1.
- All counters wrap modulo 2^CNT_WIDTH without any flag.
- **Shadows:** each hart has three shadow registers (cycle, time, instret), each DATA_SIZE wide, with a valid bit.
  - A low read (RDCYCLE / RDTIME / RDINSTRET) returns bits [DATA_SIZE-1:0] of the live value. It also loads that counter's shadow with bits [CNT_WIDTH-1:DATA_SIZE] of the same sampled value and sets the valid bit.
  - A high read returns the shadow if its valid bit is set, then clears the bit. Otherwise it returns the live high half.
- **Sampling:** values are sampled in the acceptance cycle. An increment in that same cycle is not visible to the read, i.e. the read returns the pre-increment value.
- **FSM states:** IDLE, RESP, TRAP.
  - IDLE: `req_ready` = 1. On accepting a counter op → RESP. On accepting SCALL/SBREAK → TRAP.
  - RESP: `resp_valid` = 1 for exactly one cycle, `req_ready` = 0; then → IDLE.
  - TRAP: `trap_pending` = 1, `req_ready` = 0, `resp_valid` = 0. Stays in TRAP until `trap_ack` = 1, then → IDLE in the next cycle. `trap_ack` outside TRAP is ignored.
- Counters keep running in every state.
- Accepted requests with `req_hart` ≥ NUM_HARTS return `resp_data` = 0 and touch no shadow.

## Timing
- **Reset values:**
  - All counters, prescaler, shadows and valid bits are 0; state is IDLE.
  - Outputs: `req_ready` = 1, `resp_valid` = 0, `resp_hart` = 0, `resp_data` = 0, `trap_pending` = 0, `trap_cause` = 0.
- **Latency:** a request accepted at edge N has `resp_valid` high in cycle N+1. Throughput is one request per 2 cycles.
- `req_ready` is a registered function of the state only. It does not depend combinationally on `req_valid`.
- **Simultaneous events:**
  - Retire and read of the same instret in one cycle: the read returns the old value, and the counter advances.
  - A low read by hart A does not affect hart B's shadow.
- **Reset mid-operation:** a pending response or trap is dropped with no `resp_valid` and no `trap_pending` afterwards.

## Structure
- The following go in `multicore_pkg`:
  - `t_sysop`, with RDCYCLE='b000, RDCYCLEH='b001, RDTIME='b010, RDTIMEH='b011, RDINSTRET='b100, RDINSTRETH='b101, SCALL='b110, SBREAK='b111.
  - `t_sys_state` enum {IDLE, RESP, TRAP}.
  - Constant CNT_WIDTH = 2*DATA_SIZE.
- One sub-module, `sys_counter`: a parametrised WIDTH counter with synchronous active-low reset and an increment enable. It is instantiated 2+NUM_HARTS times (cycle, time, instret[h]).

## Test plan
- **Reset then cycle read:** release reset; RDCYCLE at cycle 10, then RDCYCLEH → low = 10, high = 0; `resp_valid` one cycle after each accept.
- **Torn-read protection:** force cycle to 0x0000_0000_FFFF_FFFE; RDCYCLE returns 0xFFFF_FFFE; the counter carries; RDCYCLEH returns 0 (shadow), not 1.
- **Per-hart instret:** NUM_HARTS=4; pulse `retire[2]` 5 times and `retire[0]` once; RDINSTRET hart 2 = 5, hart 0 = 1. A retire in the accept cycle is excluded from that read.
- **Time prescaler:** TIME_DIV=50; after 250 cycles from reset, RDTIME = 5, RDTIMEH (no prior low read) = 0.
- **Trap:** SBREAK from hart 1 → `trap_pending` = 1, `trap_cause` = 1, `req_ready` = 0 for 7 cycles until `trap_ack`; IDLE the next cycle; no `resp_valid`.
- **Reset mid-response:** assert `rst_n` = 0 in the RESP cycle → `resp_valid` = 0 next cycle, all counters 0, `req_ready` = 1.

Source files
------------

// File: rtl/multicore_pkg.sv
// Shared types for the multicore execute stage: system-op encodings,
// system-unit FSM states and the default datapath/counter widths.
package multicore_pkg;

    localparam int DATA_SIZE = 32;
    localparam int CNT_WIDTH = 2 * DATA_SIZE;

    typedef enum logic [2:0] {
        RDCYCLE    = 3'b000,
        RDCYCLEH   = 3'b001,
        RDTIME     = 3'b010,
        RDTIMEH    = 3'b011,
        RDINSTRET  = 3'b100,
        RDINSTRETH = 3'b101,
        SCALL      = 3'b110,
        SBREAK     = 3'b111
    } t_sysop;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RESP = 2'd1,
        TRAP = 2'd2
    } t_sys_state;

endpackage

// File: rtl/sys_counter.sv
// Free-running WIDTH-bit counter with an increment enable; wraps silently.
module sys_counter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/sys_counter_unit.sv
// Execute-stage system unit: per-hart cycle/time/instret reads with
// torn-read-free high halves, plus SCALL/SBREAK trap signalling.
module sys_counter_unit #(
    parameter int NUM_HARTS = 4,
    parameter int DATA_SIZE = multicore_pkg::DATA_SIZE,
    parameter int CNT_WIDTH = 2 * DATA_SIZE,
    parameter int TIME_DIV  = 50,
    parameter int HART_BITS = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [HART_BITS-1:0]        req_hart,
    input  logic [2:0]                  req_op,
    output logic                        resp_valid,
    output logic [HART_BITS-1:0]        resp_hart,
    output logic [DATA_SIZE-1:0]        resp_data,
    input  logic [NUM_HARTS-1:0]        retire,
    output logic                        trap_pending,
    output logic                        trap_cause,
    input  logic                        trap_ack,
    output multicore_pkg::t_sys_state   dbg_state
);

    import multicore_pkg::*;

    localparam int PRE_W = (TIME_DIV > 1) ? $clog2(TIME_DIV) : 1;

    // Handshake: a request transfers on a rising edge where req_valid and
    // req_ready are both high; req_ready depends only on the registered state.
    t_sys_state state_q, state_d;
    logic                 accept;
    logic                 is_trap;
    logic                 hart_ok;
    logic                 hi_read;
    logic [1:0]           kind;
    logic [CNT_WIDTH-1:0] live;
    logic [DATA_SIZE-1:0] rdata;

    logic [PRE_W-1:0]     presc_q, presc_d;
    logic                 time_tick;
    logic [CNT_WIDTH-1:0] cycle_cnt, time_cnt;
    logic [CNT_WIDTH-1:0] instret_cnt [NUM_HARTS];

    logic [DATA_SIZE-1:0] shadow_q [NUM_HARTS][3];
    logic [2:0]           shvalid_q [NUM_HARTS];
    logic [HART_BITS-1:0] resp_hart_q;
    logic [DATA_SIZE-1:0] resp_data_q;
    logic                 trap_cause_q;

    assign time_tick = (presc_q == PRE_W'(TIME_DIV - 1));
    assign presc_d   = time_tick ? '0 : presc_q + PRE_W'(1);

    sys_counter #(.WIDTH(CNT_WIDTH)) u_cycle (
        .clk(clk), .rst_n(rst_n), .en_i(1'b1), .count_o(cycle_cnt)
    );

    sys_counter #(.WIDTH(CNT_WIDTH)) u_time (
        .clk(clk), .rst_n(rst_n), .en_i(time_tick), .count_o(time_cnt)
    );

    for (genvar h = 0; h < NUM_HARTS; h++) begin : gen_instret
        sys_counter #(.WIDTH(CNT_WIDTH)) u_instret (
            .clk(clk), .rst_n(rst_n), .en_i(retire[h]), .count_o(instret_cnt[h])
        );
    end

    assign accept  = req_valid && (state_q == IDLE);
    assign is_trap = (req_op == SCALL) || (req_op == SBREAK);
    assign hart_ok = int'(req_hart) < NUM_HARTS;
    assign kind    = req_op[2:1];
    assign hi_read = req_op[0];

    // Counter values are the registered ones, so an increment landing on the
    // accept edge is not visible to that read.
    always_comb begin
        live = '0;
        case (kind)
            2'd0:    live = cycle_cnt;
            2'd1:    live = time_cnt;
            2'd2:    if (hart_ok) live = instret_cnt[req_hart];
            default: live = '0;
        endcase
    end

    always_comb begin
        rdata = '0;
        if (hart_ok && !is_trap) begin
            if (!hi_read) begin
                rdata = live[DATA_SIZE-1:0];
            end else if (shvalid_q[req_hart][kind]) begin
                rdata = shadow_q[req_hart][kind];
            end else begin
                rdata = live[CNT_WIDTH-1:DATA_SIZE];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        trap_pending = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = is_trap ? TRAP : RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_d    = IDLE;
            end
            TRAP: begin
                trap_pending = 1'b1;
                if (trap_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            presc_q      <= '0;
            resp_hart_q  <= '0;
            resp_data_q  <= '0;
            trap_cause_q <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            if (accept) begin
                if (is_trap) begin
                    trap_cause_q <= req_op[0];
                end else begin
                    resp_hart_q <= req_hart;
                    resp_data_q <= rdata;
                end
            end
        end
    end

    // A low read parks the matching high half so the following high read is
    // coherent even if the low half carried in between.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                for (int k = 0; k < 3; k++) begin
                    shadow_q[h][k] <= '0;
                end
                shvalid_q[h] <= '0;
            end
        end else if (accept && !is_trap && hart_ok) begin
            if (!hi_read) begin
                shadow_q[req_hart][kind]  <= live[CNT_WIDTH-1:DATA_SIZE];
                shvalid_q[req_hart][kind] <= 1'b1;
            end else begin
                shvalid_q[req_hart][kind] <= 1'b0;
            end
        end
    end

    assign resp_hart  = resp_hart_q;
    assign resp_data  = resp_data_q;
    assign trap_cause = trap_cause_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_sys_counter_unit.sv
// Directed bench for sys_counter_unit: counter reads, shadowed high halves,
// time prescaler, traps and reset while busy.
module tb_sys_counter_unit;

    import multicore_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_hart;
    logic [2:0]  req_op;
    logic        resp_valid;
    logic [1:0]  resp_hart;
    logic [31:0] resp_data;
    logic [3:0]  retire;
    logic        trap_pending;
    logic        trap_cause;
    logic        trap_ack;
    t_sys_state  dbg_state;

    int checks;
    int failures;
    logic [31:0] exp_q[$];

    sys_counter_unit #(
        .NUM_HARTS(4), .DATA_SIZE(32), .CNT_WIDTH(64), .TIME_DIV(50)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_hart(req_hart), .req_op(req_op),
        .resp_valid(resp_valid), .resp_hart(resp_hart), .resp_data(resp_data),
        .retire(retire),
        .trap_pending(trap_pending), .trap_cause(trap_cause), .trap_ack(trap_ack),
        .dbg_state(dbg_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Issue one counter read from a negedge in IDLE; returns at a negedge in IDLE.
    task automatic send(input string tag, input int hart, input logic [2:0] op,
                        input logic [31:0] exp);
        chk({tag, "_ready"}, req_ready, 1);
        exp_q.push_back(exp);
        req_valid = 1'b1;
        req_hart  = hart[1:0];
        req_op    = op;
        @(negedge clk);
        req_valid = 1'b0;
        retire    = '0;
        chk({tag, "_valid"}, resp_valid, 1);
        chk({tag, "_hart"}, resp_hart, hart);
        chk({tag, "_busy"}, req_ready, 0);
        chk({tag, "_data"}, resp_data, exp_q.pop_front());
        @(negedge clk);
        chk({tag, "_pulse"}, resp_valid, 0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_hart  = '0;
        req_op    = RDCYCLE;
        retire    = '0;
        trap_ack  = 1'b0;

        // Reset state
        tick(3);
        chk("rst_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_hart", resp_hart, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_trap_pending", trap_pending, 0);
        chk("rst_trap_cause", trap_cause, 0);
        chk("rst_state", dbg_state, IDLE);

        // Cycle read at cycle 10, then shadowed high half
        rst_n = 1'b1;
        tick(10);
        send("cyc_lo", 0, RDCYCLE, 32'd10);
        send("cyc_hi", 0, RDCYCLEH, 32'd0);

        // Torn-read protection across the 32-bit carry
        force dut.u_cycle.cnt_q = 64'h0000_0000_FFFF_FFFE;
        #1;
        release dut.u_cycle.cnt_q;
        send("torn_lo", 0, RDCYCLE, 32'hFFFF_FFFE);
        send("torn_other_hart", 3, RDCYCLEH, 32'd1);
        send("torn_hi_shadow", 0, RDCYCLEH, 32'd0);
        send("torn_hi_live", 0, RDCYCLEH, 32'd1);

        // Per-hart instret
        for (int i = 0; i < 5; i++) begin
            retire = (i == 0) ? 4'b0101 : 4'b0100;
            @(negedge clk);
        end
        retire = '0;
        send("ir_h2", 2, RDINSTRET, 32'd5);
        send("ir_h0", 0, RDINSTRET, 32'd1);
        send("ir_h1", 1, RDINSTRET, 32'd0);
        retire = 4'b0100;
        send("ir_same_cycle", 2, RDINSTRET, 32'd5);
        send("ir_advanced", 2, RDINSTRET, 32'd6);
        send("ir_hi", 2, RDINSTRETH, 32'd0);

        // SBREAK held for 7 cycles until acknowledged
        req_valid = 1'b1;
        req_hart  = 2'd1;
        req_op    = SBREAK;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            chk("sbrk_pending", trap_pending, 1);
            chk("sbrk_cause", trap_cause, 1);
            chk("sbrk_ready", req_ready, 0);
            chk("sbrk_no_resp", resp_valid, 0);
            if (i < 6) @(negedge clk);
        end
        chk("sbrk_state", dbg_state, TRAP);
        trap_ack = 1'b1;
        @(negedge clk);
        trap_ack = 1'b0;
        chk("sbrk_idle_ready", req_ready, 1);
        chk("sbrk_idle_pending", trap_pending, 0);
        chk("sbrk_idle_resp", resp_valid, 0);

        // SCALL with immediate ack, then ack while idle is ignored
        req_valid = 1'b1;
        req_hart  = 2'd0;
        req_op    = SCALL;
        @(negedge clk);
        req_valid = 1'b0;
        chk("scall_pending", trap_pending, 1);
        chk("scall_cause", trap_cause, 0);
        trap_ack = 1'b1;
        @(negedge clk);
        chk("scall_idle", req_ready, 1);
        @(negedge clk);
        trap_ack = 1'b0;
        chk("idle_ack_ready", req_ready, 1);
        chk("idle_ack_pending", trap_pending, 0);

        // Reset during RESP
        req_valid = 1'b1;
        req_hart  = 2'd3;
        req_op    = RDCYCLE;
        @(negedge clk);
        req_valid = 1'b0;
        chk("mid_resp_valid", resp_valid, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_resp_dropped", resp_valid, 0);
        chk("mid_resp_ready", req_ready, 1);
        chk("mid_resp_data", resp_data, 0);
        chk("mid_resp_hart", resp_hart, 0);

        // Reset during TRAP
        rst_n     = 1'b1;
        req_valid = 1'b1;
        req_hart  = 2'd1;
        req_op    = SBREAK;
        @(negedge clk);
        req_valid = 1'b0;
        chk("mid_trap_pending", trap_pending, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_trap_dropped", trap_pending, 0);
        chk("mid_trap_cause", trap_cause, 0);
        chk("mid_trap_ready", req_ready, 1);
        @(negedge clk);

        // Counters cleared, then time prescaler boundary around 250 cycles
        rst_n = 1'b1;
        send("post_rst_cycle", 0, RDCYCLE, 32'd0);
        send("post_rst_instret", 2, RDINSTRET, 32'd0);
        tick(245);
        send("time_249", 0, RDTIME, 32'd4);
        send("time_hi_no_low", 1, RDTIMEH, 32'd0);
        send("time_253", 1, RDTIME, 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
